// File: rtl/tower_placer_control.sv
// Tower-placer controller: sequences cursor erase/move/redraw and tower placement on the grid.
// Optional build macro PLACE_LOCK_EN adds a per-cell occupancy map that rejects placing on an occupied cell.
module tower_placer_control #(
  parameter int GRID_COLS  = 8,
  parameter int GRID_ROWS  = 6,
  parameter int DONE_GUARD = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_right,
  input  logic       key_down,
  input  logic       key_place,
  input  logic       valid,
  input  logic       square_done,
  input  logic       erase_square_done,
  input  logic       tower_done,
  output logic       top_left,
  output logic       draw_square,
  output logic       move_right,
  output logic       move_down,
  output logic       move_right_wait,
  output logic       move_down_wait,
  output logic       draw_tower,
  output logic       erase_square_right,
  output logic       erase_square_down,
  output logic       erase_square_tower,
  output logic       busy,
  output logic [2:0] cell_x,
  output logic [2:0] cell_y,
  output logic [5:0] towers_placed
);

  localparam int         NCELLS    = GRID_COLS * GRID_ROWS;
  localparam logic [2:0] X_MAX     = 3'(GRID_COLS - 1);
  localparam logic [2:0] Y_MAX     = 3'(GRID_ROWS - 1);
  localparam logic [5:0] TOWER_MAX = 6'(NCELLS);
  localparam logic [1:0] GUARD_MIN = 2'(DONE_GUARD);

  localparam int SB_TL  = 0;
  localparam int SB_DS  = 1;
  localparam int SB_MR  = 2;
  localparam int SB_MD  = 3;
  localparam int SB_MRW = 4;
  localparam int SB_MDW = 5;
  localparam int SB_DT  = 6;
  localparam int SB_ER  = 7;
  localparam int SB_ED  = 8;
  localparam int SB_ET  = 9;

  typedef enum logic [3:0] {
    S_INIT,
    S_DRAW_SQ,
    S_IDLE,
    S_ERASE_R,
    S_MOVE_R,
    S_MOVE_R_W,
    S_ERASE_D,
    S_MOVE_D,
    S_MOVE_D_W,
    S_ERASE_T,
    S_DRAW_TW
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  guard_q, guard_d;
  logic [2:0]  keys_q, keys_d;
  logic [2:0]  cell_x_q, cell_x_d;
  logic [2:0]  cell_y_q, cell_y_d;
  logic [5:0]  towers_q, towers_d;
  logic [9:0]  strobe_q, strobe_d;
  logic        busy_q, busy_d;

  logic        rise_right, rise_down, rise_place;
  logic        guard_ok;
  logic        place_blocked;

  // keys_q holds last cycle's levels as {right, down, place}
  assign rise_right = key_right & ~keys_q[2];
  assign rise_down  = key_down  & ~keys_q[1];
  assign rise_place = key_place & ~keys_q[0];
  assign guard_ok   = (guard_q >= GUARD_MIN);

`ifdef PLACE_LOCK_EN
  localparam int IDXW = $clog2(NCELLS);
  logic [NCELLS-1:0] occ_q, occ_d;
  logic [IDXW-1:0]   cell_idx;

  assign cell_idx      = IDXW'(cell_y_q) * IDXW'(GRID_COLS) + IDXW'(cell_x_q);
  assign place_blocked = occ_q[cell_idx];
`else
  assign place_blocked = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cell_x_d = cell_x_q;
    cell_y_d = cell_y_q;
    towers_d = towers_q;
    keys_d   = {key_right, key_down, key_place};
`ifdef PLACE_LOCK_EN
    occ_d    = occ_q;
`endif

    case (state_q)
      // Stay one extra cycle so the registered top_left strobe is actually seen.
      S_INIT:     if (strobe_q[SB_TL]) state_d = S_DRAW_SQ;
      S_DRAW_SQ:  if (guard_ok && square_done) state_d = S_IDLE;
      S_IDLE: begin
        if (rise_place) begin
          if (!place_blocked) state_d = S_ERASE_T;
        end else if (rise_right) begin
          state_d = S_ERASE_R;
        end else if (rise_down) begin
          state_d = S_ERASE_D;
        end
      end
      S_ERASE_R:  if (guard_ok && erase_square_done) state_d = S_MOVE_R;
      S_MOVE_R: begin
        if (valid) begin
          state_d  = S_MOVE_R_W;
          cell_x_d = (cell_x_q == X_MAX) ? 3'd0 : cell_x_q + 3'd1;
        end
      end
      S_MOVE_R_W: state_d = S_DRAW_SQ;
      S_ERASE_D:  if (guard_ok && erase_square_done) state_d = S_MOVE_D;
      S_MOVE_D: begin
        if (valid) begin
          state_d  = S_MOVE_D_W;
          cell_y_d = (cell_y_q == Y_MAX) ? 3'd0 : cell_y_q + 3'd1;
        end
      end
      S_MOVE_D_W: state_d = S_DRAW_SQ;
      S_ERASE_T:  if (guard_ok && erase_square_done) state_d = S_DRAW_TW;
      S_DRAW_TW: begin
        if (guard_ok && tower_done) begin
          state_d = S_DRAW_SQ;
          if (towers_q != TOWER_MAX) towers_d = towers_q + 6'd1;
`ifdef PLACE_LOCK_EN
          occ_d[cell_idx] = 1'b1;
`endif
        end
      end
      default:    state_d = S_INIT;
    endcase

    // Done flags are sticky from the previous operation, so each state ignores them briefly.
    if (state_d != state_q)   guard_d = 2'd0;
    else if (guard_q == 2'd3) guard_d = guard_q;
    else                      guard_d = guard_q + 2'd1;

    strobe_d = '0;
    case (state_d)
      S_INIT:     strobe_d[SB_TL]  = 1'b1;
      S_DRAW_SQ:  strobe_d[SB_DS]  = 1'b1;
      S_ERASE_R:  strobe_d[SB_ER]  = 1'b1;
      S_MOVE_R:   strobe_d[SB_MR]  = 1'b1;
      S_MOVE_R_W: strobe_d[SB_MRW] = 1'b1;
      S_ERASE_D:  strobe_d[SB_ED]  = 1'b1;
      S_MOVE_D:   strobe_d[SB_MD]  = 1'b1;
      S_MOVE_D_W: strobe_d[SB_MDW] = 1'b1;
      S_ERASE_T:  strobe_d[SB_ET]  = 1'b1;
      S_DRAW_TW:  strobe_d[SB_DT]  = 1'b1;
      default:    strobe_d = '0;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_INIT;
      guard_q  <= 2'd0;
      keys_q   <= 3'd0;
      cell_x_q <= 3'd0;
      cell_y_q <= 3'd0;
      towers_q <= 6'd0;
      strobe_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      guard_q  <= guard_d;
      keys_q   <= keys_d;
      cell_x_q <= cell_x_d;
      cell_y_q <= cell_y_d;
      towers_q <= towers_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
    end
  end

`ifdef PLACE_LOCK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) occ_q <= '0;
    else         occ_q <= occ_d;
  end
`endif

  assign top_left           = strobe_q[SB_TL];
  assign draw_square        = strobe_q[SB_DS];
  assign move_right         = strobe_q[SB_MR];
  assign move_down          = strobe_q[SB_MD];
  assign move_right_wait    = strobe_q[SB_MRW];
  assign move_down_wait     = strobe_q[SB_MDW];
  assign draw_tower         = strobe_q[SB_DT];
  assign erase_square_right = strobe_q[SB_ER];
  assign erase_square_down  = strobe_q[SB_ED];
  assign erase_square_tower = strobe_q[SB_ET];
  assign busy               = busy_q;
  assign cell_x             = cell_x_q;
  assign cell_y             = cell_y_q;
  assign towers_placed      = towers_q;

endmodule

// File: tb/tb_tower_placer_control.sv
// Directed bench for tower_placer_control with a small behavioural datapath (sticky done flags).
module tb_tower_placer_control;

  localparam int DLY = 5;

  localparam logic [9:0] C_TL  = 10'h200;
  localparam logic [9:0] C_DS  = 10'h100;
  localparam logic [9:0] C_MR  = 10'h080;
  localparam logic [9:0] C_MD  = 10'h040;
  localparam logic [9:0] C_MRW = 10'h020;
  localparam logic [9:0] C_MDW = 10'h010;
  localparam logic [9:0] C_DT  = 10'h008;
  localparam logic [9:0] C_ER  = 10'h004;
  localparam logic [9:0] C_ED  = 10'h002;
  localparam logic [9:0] C_ET  = 10'h001;

  logic clk = 1'b0;
  logic resetn;
  logic key_right, key_down, key_place;
  logic valid, square_done, erase_square_done, tower_done;
  logic top_left, draw_square, move_right, move_down, move_right_wait, move_down_wait;
  logic draw_tower, erase_square_right, erase_square_down, erase_square_tower;
  logic busy;
  logic [2:0] cell_x, cell_y;
  logic [5:0] towers_placed;

  int n_checks = 0;
  int n_fail   = 0;

  int sq_cnt = 0, es_cnt = 0, tw_cnt = 0, mv_cnt = 0;
  logic sq_m = 1'b0, es_m = 1'b0, tw_m = 1'b0, sq_force = 1'b0;

  logic [9:0] run_code [8];
  int         run_len  [8];
  int         nruns;

  always #5 clk = ~clk;

  tower_placer_control dut (
    .clk(clk), .resetn(resetn),
    .key_right(key_right), .key_down(key_down), .key_place(key_place),
    .valid(valid), .square_done(square_done),
    .erase_square_done(erase_square_done), .tower_done(tower_done),
    .top_left(top_left), .draw_square(draw_square),
    .move_right(move_right), .move_down(move_down),
    .move_right_wait(move_right_wait), .move_down_wait(move_down_wait),
    .draw_tower(draw_tower), .erase_square_right(erase_square_right),
    .erase_square_down(erase_square_down), .erase_square_tower(erase_square_tower),
    .busy(busy), .cell_x(cell_x), .cell_y(cell_y), .towers_placed(towers_placed)
  );

  function automatic logic [9:0] strobes();
    return {top_left, draw_square, move_right, move_down, move_right_wait,
            move_down_wait, draw_tower, erase_square_right, erase_square_down,
            erase_square_tower};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Datapath model: done sets on the 5th cycle of its strobe, stays set until cycle 2 of the next run.
  task automatic model();
    if (draw_square) begin
      if (sq_cnt == 1) sq_m = 1'b0;
      if (sq_cnt == DLY - 1) sq_m = 1'b1;
      sq_cnt++;
    end else sq_cnt = 0;
    if (erase_square_right | erase_square_down | erase_square_tower) begin
      if (es_cnt == 1) es_m = 1'b0;
      if (es_cnt == DLY - 1) es_m = 1'b1;
      es_cnt++;
    end else es_cnt = 0;
    if (draw_tower) begin
      if (tw_cnt == 1) tw_m = 1'b0;
      if (tw_cnt == DLY - 1) tw_m = 1'b1;
      tw_cnt++;
    end else tw_cnt = 0;
    valid = (move_right | move_down) && (mv_cnt == 2);
    if (move_right | move_down) mv_cnt++;
    else mv_cnt = 0;
    square_done       = sq_m | sq_force;
    erase_square_done = es_m;
    tower_done        = tw_m;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model();
  endtask

  // Records runs of identical strobe vectors until the controller is idle again.
  task automatic capture(input int max_cyc, input logic [2:0] mid_keys);
    logic [9:0] sv, cur;
    int len;
    bit reached;
    nruns = 0; cur = '0; len = 0; reached = 0;
    for (int c = 0; c < max_cyc; c++) begin
      step();
      if (c == 0) begin key_right = 0; key_down = 0; key_place = 0; end
      if (c == 3) begin key_right = mid_keys[2]; key_down = mid_keys[1]; key_place = mid_keys[0]; end
      if (c == 4) begin key_right = 0; key_down = 0; key_place = 0; end
      sv = strobes();
      chk("onehot", {31'd0, $onehot0(sv)}, 32'd1);
      if (busy === 1'b0) begin
        if (len > 0 && nruns < 8) begin run_code[nruns] = cur; run_len[nruns] = len; nruns++; end
        chk("idle strobes", {22'd0, sv}, 32'd0);
        reached = 1;
        break;
      end
      if (sv != cur) begin
        if (len > 0 && nruns < 8) begin run_code[nruns] = cur; run_len[nruns] = len; nruns++; end
        cur = sv; len = 1;
      end else len++;
    end
    if (!reached) chk("idle timeout", 32'd0, 32'd1);
  endtask

  task automatic op(input logic r, input logic d, input logic p, input logic [2:0] mid);
    key_right = r; key_down = d; key_place = p;
    capture(200, mid);
  endtask

  task automatic chk_seq(input string tag, input int n,
                         input logic [9:0] c0, input int l0, input logic [9:0] c1, input int l1,
                         input logic [9:0] c2, input int l2, input logic [9:0] c3, input int l3);
    logic [9:0] ec [4];
    int el [4];
    ec[0] = c0; ec[1] = c1; ec[2] = c2; ec[3] = c3;
    el[0] = l0; el[1] = l1; el[2] = l2; el[3] = l3;
    chk($sformatf("%s nruns", tag), nruns, n);
    for (int i = 0; i < n && i < nruns; i++) begin
      chk($sformatf("%s run%0d code", tag, i), {22'd0, run_code[i]}, {22'd0, ec[i]});
      chk($sformatf("%s run%0d len", tag, i), run_len[i], el[i]);
    end
  endtask

  task automatic chk_cell(input string tag, input int x, input int y);
    chk({tag, " cell_x"}, {29'd0, cell_x}, x);
    chk({tag, " cell_y"}, {29'd0, cell_y}, y);
  endtask

  initial begin
    bit seen;
    resetn = 0; key_right = 0; key_down = 0; key_place = 0;
    valid = 0; square_done = 0; erase_square_done = 0; tower_done = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst strobes", {22'd0, strobes()}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk_cell("rst", 0, 0);
    chk("rst towers", {26'd0, towers_placed}, 32'd0);

    // Power-up: top_left then draw_square until done
    resetn = 1;
    capture(100, 3'b000);
    chk_seq("init", 2, C_TL, 1, C_DS, DLY, '0, 0, '0, 0);
    chk_cell("init", 0, 0);

    // Eight rights wrap cell_x back to 0
    for (int i = 0; i < 8; i++) begin
      op(1, 0, 0, 3'b000);
      chk_seq("right", 4, C_ER, DLY, C_MR, 3, C_MRW, 1, C_DS, DLY);
      chk_cell("right", (i + 1) % 8, 0);
    end

    // Right and down together: right wins; a down pressed while busy is dropped
    op(1, 1, 0, 3'b010);
    chk_seq("prio", 4, C_ER, DLY, C_MR, 3, C_MRW, 1, C_DS, DLY);
    chk_cell("prio", 1, 0);
    repeat (4) begin
      step();
      chk("no queued busy", {31'd0, busy}, 32'd0);
      chk("no queued strobes", {22'd0, strobes()}, 32'd0);
    end

    // Move to (2,3) and place
    op(1, 0, 0, 3'b000);
    chk_cell("to x2", 2, 0);
    for (int i = 0; i < 3; i++) begin
      op(0, 1, 0, 3'b000);
      chk_seq("down", 4, C_ED, DLY, C_MD, 3, C_MDW, 1, C_DS, DLY);
      chk_cell("down", 2, i + 1);
    end
    op(0, 0, 1, 3'b000);
    chk_seq("place", 3, C_ET, DLY, C_DT, DLY, C_DS, DLY, '0, 0);
    chk("place towers", {26'd0, towers_placed}, 32'd1);

    op(0, 0, 1, 3'b000);
`ifdef PLACE_LOCK_EN
    chk("relock nruns", nruns, 0);
    chk("relock towers", {26'd0, towers_placed}, 32'd1);
`else
    chk_seq("replace", 3, C_ET, DLY, C_DT, DLY, C_DS, DLY, '0, 0);
    chk("replace towers", {26'd0, towers_placed}, 32'd2);
`endif

    // Down wrap 3 -> 4 -> 5 -> 0
    for (int i = 0; i < 3; i++) begin
      op(0, 1, 0, 3'b000);
      chk_cell("down wrap", 2, (4 + i) % 6);
    end

    // Sticky square_done held high: draw_square lasts exactly the guard plus one cycle
    sq_force = 1;
    op(1, 0, 0, 3'b000);
    sq_force = 0;
    chk_seq("sticky", 4, C_ER, DLY, C_MR, 3, C_MRW, 1, C_DS, 3);
    chk_cell("sticky", 3, 0);

`ifndef PLACE_LOCK_EN
    // Saturation at 48
    for (int k = 1; k <= 47; k++) begin
      op(0, 0, 1, 3'b000);
      chk($sformatf("sat towers k=%0d", k), {26'd0, towers_placed}, (2 + k > 48) ? 48 : 2 + k);
    end
`endif

    // Reset during draw_tower aborts immediately
    key_place = 1;
    step();
    key_place = 0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (draw_tower === 1'b1) seen = 1;
    end
    chk("reached draw_tower", {31'd0, seen}, 32'd1);
    resetn = 0;
    #1;
    chk("abort strobes", {22'd0, strobes()}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk_cell("abort", 0, 0);
    chk("abort towers", {26'd0, towers_placed}, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1;
    capture(100, 3'b000);
    chk_seq("reinit", 2, C_TL, 1, C_DS, DLY, '0, 0, '0, 0);
    chk_cell("reinit", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
